// File: rtl/icache_dm_param_if.sv
// Purpose: CPU fetch port, refill port and statistics of the direct-mapped
//          instruction cache, bundled as one interface.
// Signals:
//   addr/ce_n/oe_n/flush_i  CPU -> cache fetch request and flush pulse
//   rdata/hold_o            cache -> CPU instruction word and stall
//   mem_req/mem_addr        cache -> memory line refill request
//   mem_rvalid/mem_rdata    memory -> cache refill beats
//   hit_cnt/miss_cnt        cache statistics
// Modports: slave = cache side, master = CPU/memory side.
interface icache_dm_param_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
);
  logic [ADDR_W-1:0] addr;
  logic              ce_n;
  logic              oe_n;
  logic [31:0]       rdata;
  logic              hold_o;
  logic              flush_i;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  modport slave (
    input  addr, ce_n, oe_n, flush_i, mem_rvalid, mem_rdata,
    output rdata, hold_o, mem_req, mem_addr, hit_cnt, miss_cnt
  );

  modport master (
    output addr, ce_n, oe_n, flush_i, mem_rvalid, mem_rdata,
    input  rdata, hold_o, mem_req, mem_addr, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/icache_dm_param.sv
// Purpose: parametrised direct-mapped read-only instruction cache. Hits answer
//          combinationally; a miss stalls the CPU and refills the whole line
//          with a word-by-word burst, then spends one settle cycle in DONE.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      icache_dm_param_if.slave (fetch, refill and counter signals)
module icache_dm_param #(
  parameter int unsigned LINES      = 8,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned CNT_W      = 32
) (
  input logic              clk,
  input logic              reset_n,
  icache_dm_param_if.slave bus
);
  localparam int unsigned WSEL_W = $clog2(LINE_WORDS);
  localparam int unsigned OFS_W  = WSEL_W + 2;
  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFS_W;
  localparam int unsigned DEPTH  = LINES * LINE_WORDS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [31:0]       r_data [DEPTH];

  logic [TAG_W-1:0]  r_line_tag;
  logic [IDX_W-1:0]  r_line_idx;
  logic [WSEL_W-1:0] r_cnt;
  logic              r_flushed;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic              w_req;
  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [WSEL_W-1:0] w_word;
  logic              w_hit;
  logic              w_beat;
  logic              w_last;
  logic [31:0]       w_rdata;
  logic              w_hold;
  logic              w_serve_hit;
  logic              w_start_miss;
  logic              w_unused;

  // Address split and tag compare
  assign w_req    = !bus.ce_n && !bus.oe_n;
  assign w_tag    = bus.addr[ADDR_W-1:IDX_W+OFS_W];
  assign w_idx    = bus.addr[IDX_W+OFS_W-1:OFS_W];
  assign w_word   = bus.addr[OFS_W-1:2];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_unused = ^bus.addr[1:0];

  // Beats arriving while no burst is outstanding are dropped
  assign w_beat = (r_state == S_REFILL) && r_mem_req && bus.mem_rvalid;
  assign w_last = w_beat && (r_cnt == WSEL_W'(LINE_WORDS - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_req && !w_hit) w_next_state = S_REFILL;
      S_REFILL: if (w_last)          w_next_state = S_DONE;
      S_DONE:                        w_next_state = S_IDLE;
      default:                       w_next_state = S_IDLE;
    endcase
  end

  // Output logic: hits are answered in the request cycle
  always_comb begin
    w_rdata      = '0;
    w_hold       = 1'b0;
    w_serve_hit  = 1'b0;
    w_start_miss = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_rdata     = r_data[{w_idx, w_word}];
            w_serve_hit = 1'b1;
          end else begin
            w_hold       = 1'b1;
            w_start_miss = 1'b1;
          end
        end
      end
      S_REFILL, S_DONE: w_hold = 1'b1;
      default:          w_hold = 1'b0;
    endcase
  end

  // Control registers, valid bits and statistics
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid    <= '0;
      r_line_tag <= '0;
      r_line_idx <= '0;
      r_cnt      <= '0;
      r_flushed  <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_serve_hit) r_hit_cnt <= r_hit_cnt + CNT_W'(1);

      if (w_start_miss) begin
        r_line_tag <= w_tag;
        r_line_idx <= w_idx;
        r_mem_addr <= {bus.addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
        r_mem_req  <= 1'b1;
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end

      if (w_beat) r_cnt <= w_last ? '0 : r_cnt + WSEL_W'(1);
      if (w_last) r_mem_req <= 1'b0;

      // A flush seen at any point of the burst keeps the refilled line invalid
      if (w_start_miss)                             r_flushed <= 1'b0;
      else if (r_state == S_REFILL && bus.flush_i)  r_flushed <= 1'b1;

      if (bus.flush_i)                   r_valid             <= '0;
      else if (w_start_miss)             r_valid[w_idx]      <= 1'b0;
      else if (w_last && !r_flushed)     r_valid[r_line_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset
  always_ff @(posedge clk) begin
    if (w_beat) r_data[{r_line_idx, r_cnt}] <= bus.mem_rdata;
    if (w_last) r_tag[r_line_idx]           <= r_line_tag;
  end

  assign bus.rdata    = w_rdata;
  assign bus.hold_o   = w_hold;
  assign bus.mem_req  = r_mem_req;
  assign bus.mem_addr = r_mem_addr;
  assign bus.hit_cnt  = r_hit_cnt;
  assign bus.miss_cnt = r_miss_cnt;
endmodule
